// File: rtl/ps2_dbg_pkg.sv
// Shared constants and mode encodings for the PS/2 debug capture path.
// Imported by the byte logger, its interface and the top-level HEXDATA mux.
package ps2_dbg_pkg;

    localparam int HEX_W      = 32;
    localparam int PS2_BYTE_W = 8;

    typedef enum logic {
        LOG_ONESHOT = 1'b0,
        LOG_ROLLING = 1'b1
    } log_mode_e;

endpackage

// File: rtl/ps2_byte_logger_if.sv
// Bundle between the PS/2 receiver side, the control switches and the byte logger.
// Handshake: in_ready is a level from the receiver's clock domain. Each rising edge
// delivers one item on in_data, which stays stable while in_ready is high. There is
// no backpressure; items arriving while hold=1 or while a one-shot log is full are lost.
interface ps2_byte_logger_if
    import ps2_dbg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int PER_WORD = HEX_W / DATA_W;
    localparam int PAGES    = DEPTH / PER_WORD;
    localparam int PAGE_W   = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              clr;
    logic              mode;
    logic              hold;
    logic [PAGE_W-1:0] page;
    logic [HEX_W-1:0]  hex_word;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              dropped;
    logic              wrapped;

    modport master (
        output in_ready, in_data, clr, mode, hold, page,
        input  hex_word, count, full, dropped, wrapped
    );

    modport slave (
        input  in_ready, in_data, clr, mode, hold, page,
        output hex_word, count, full, dropped, wrapped
    );

endinterface

// File: rtl/ps2_byte_logger_edge_sync_rise.sv
// Three-flop synchroniser for an asynchronous level, producing a one-clock pulse
// on each rising edge. Only rstn clears the flops so a buffer clear cannot re-fire a held level.
module edge_sync_rise (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic pulse
);

    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    // sh[0] is the metastability-exposed stage; the edge is detected one stage later.
    assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/ps2_byte_logger.sv
// Capture buffer for PS/2 receiver items with one-shot or rolling logging,
// drop/wrap flags and paged 32-bit readout for the hex display.
module ps2_byte_logger
    import ps2_dbg_pkg::*;
#(
    parameter int DATA_W = PS2_BYTE_W,
    parameter int DEPTH  = 8
) (
    input logic              clk,
    input logic              rstn,
    ps2_byte_logger_if.slave bus
);

    localparam int PER_WORD = HEX_W / DATA_W;
    localparam int PAGES    = DEPTH / PER_WORD;
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic              wr_edge;
    logic              wr;
    log_mode_e         mode_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              full_w;
    logic              dropped_q;
    logic              wrapped_q;
    logic [ADDR_W-1:0] log_idx;
    logic [HEX_W-1:0]  hex_next;
    logic [HEX_W-1:0]  hex_q;

    edge_sync_rise u_sync (
        .clk   (clk),
        .rstn  (rstn),
        .din   (bus.in_ready),
        .pulse (wr_edge)
    );

    // hold gates the strobe itself, so a held-off pulse is discarded rather than deferred.
    assign wr     = wr_edge & ~bus.hold;
    assign full_w = (count_q == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rstn || bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
            wrapped_q <= 1'b0;
            mode_q    <= log_mode_e'(bus.mode);
        end else if (wr) begin
            if (mode_q == LOG_ROLLING || !full_w) begin
                mem[wr_ptr] <= bus.in_data;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
            end
            if (!full_w) begin
                count_q <= count_q + CNT_W'(1);
            end else if (mode_q == LOG_ROLLING) begin
                wrapped_q <= 1'b1;
            end else begin
                dropped_q <= 1'b1;
            end
        end
    end

    // Once full, wr_ptr points at the oldest item, so logical index i lives at wr_ptr+i.
    always_comb begin
        hex_next = '0;
        log_idx  = '0;
        if (int'(bus.page) < PAGES) begin
            for (int k = 0; k < PER_WORD; k++) begin
                log_idx = ADDR_W'(int'(bus.page) * PER_WORD + k);
                hex_next[HEX_W-1-k*DATA_W -: DATA_W] =
                    mem[full_w ? ADDR_W'(wr_ptr + log_idx) : log_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || bus.clr) begin
            hex_q <= '0;
        end else begin
            hex_q <= hex_next;
        end
    end

    assign bus.hex_word = hex_q;
    assign bus.count    = count_q;
    assign bus.full     = full_w;
    assign bus.dropped  = dropped_q;
    assign bus.wrapped  = wrapped_q;

endmodule

// File: tb/tb_ps2_byte_logger.sv
// Directed bench for ps2_byte_logger: a DEPTH=8 instance plus a DEPTH=4 instance
// (single page) sharing the same stimulus, used for the out-of-range page case.
module tb_ps2_byte_logger;
  import ps2_dbg_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ps2_byte_logger_if #(.DATA_W(8), .DEPTH(8)) bus ();
  ps2_byte_logger_if #(.DATA_W(8), .DEPTH(4)) bus_s ();

  ps2_byte_logger #(.DATA_W(8), .DEPTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  ps2_byte_logger #(.DATA_W(8), .DEPTH(4)) dut_s (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_s.slave)
  );

  assign bus_s.in_ready = bus.in_ready;
  assign bus_s.in_data  = bus.in_data;
  assign bus_s.clr      = bus.clr;
  assign bus_s.mode     = bus.mode;
  assign bus_s.hold     = bus.hold;

  // scoreboard
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d);
    bus.in_data  = d;
    bus.in_ready = 1'b1;
    cycles(4);
    bus.in_ready = 1'b0;
    cycles(4);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    cycles(1);
    bus.clr = 1'b0;
    cycles(1);
  endtask

  // Reads main-instance pages 0,1,... comparing against queued expectations.
  task automatic check_pages(input string tag);
    int p;
    p = 0;
    while (exp_q.size() > 0) begin
      bus.page = 1'(p);
      cycles(1);
      check($sformatf("%s_pg%0d", tag, p), bus.hex_word, exp_q.pop_front());
      p++;
    end
  endtask

  task automatic check_small_page(input string tag, input int p, input logic [31:0] exp);
    bus_s.page = 1'(p);
    cycles(1);
    check(tag, bus_s.hex_word, exp);
  endtask

  task automatic check_status(input string tag, input int cnt, input logic f,
                              input logic d, input logic w);
    check({tag, "_count"},   32'(bus.count), 32'(cnt));
    check({tag, "_full"},    32'(bus.full), 32'(f));
    check({tag, "_dropped"}, 32'(bus.dropped), 32'(d));
    check({tag, "_wrapped"}, 32'(bus.wrapped), 32'(w));
  endtask

  initial begin
    bus.in_ready = 1'b0;
    bus.in_data  = '0;
    bus.clr      = 1'b0;
    bus.mode     = 1'b0;
    bus.hold     = 1'b0;
    bus.page     = '0;
    bus_s.page   = '0;

    // reset state
    cycles(3);
    check_status("reset", 0, 1'b0, 1'b0, 1'b0);
    check("reset_hex", bus.hex_word, 32'h0);
    rstn = 1'b1;
    cycles(1);

    // one-shot fill of 8 items
    for (int i = 1; i <= 8; i++) pulse(8'(i * 8'h11));
    check_status("fill8", 8, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h55667788);
    check_pages("fill8");

    // one more while full: dropped, contents frozen
    pulse(8'h99);
    check_status("drop", 8, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'h55667788);
    check_pages("drop");

    // rolling mode, 10 items overwrite the two oldest
    bus.mode = 1'b1;
    do_clr();
    check_status("clr_roll", 0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) pulse(8'(i));
    check_status("roll", 8, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(32'h03040506);
    exp_q.push_back(32'h0708090A);
    check_pages("roll");
    check_small_page("roll_s_pg0", 0, 32'h0708090A);
    check("roll_s_wrapped", 32'(bus_s.wrapped), 32'h1);

    // partial one-shot capture, unwritten slots read zero
    bus.mode = 1'b0;
    do_clr();
    pulse(8'hAA);
    pulse(8'hBB);
    pulse(8'hCC);
    check_status("part", 3, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'hAABBCC00);
    exp_q.push_back(32'h00000000);
    check_pages("part");
    check_small_page("part_s_pg0", 0, 32'hAABBCC00);
    check_small_page("part_s_pg_oob", 1, 32'h0);

    // long in_ready level: one write, landing two edges after the first sampling edge
    bus.in_data  = 8'hDD;
    bus.in_ready = 1'b1;
    cycles(1);
    check("long_e0", 32'(bus.count), 32'd3);
    cycles(1);
    check("long_e1", 32'(bus.count), 32'd3);
    cycles(1);
    check("long_e2", 32'(bus.count), 32'd4);
    cycles(47);
    bus.in_ready = 1'b0;
    cycles(4);
    check("long_once", 32'(bus.count), 32'd4);

    // hold across a whole pulse: item lost
    bus.hold = 1'b1;
    pulse(8'hEE);
    bus.hold = 1'b0;
    cycles(2);
    check("hold_count", 32'(bus.count), 32'd4);

    // mode pin change mid-capture is ignored until the next clr
    bus.mode = 1'b1;
    for (int i = 1; i <= 5; i++) pulse(8'(8'hF0 + i));
    check_status("modepin", 8, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(32'hAABBCCDD);
    exp_q.push_back(32'hF1F2F3F4);
    check_pages("modepin");

    // clr coinciding with a write strobe
    bus.mode     = 1'b0;
    bus.in_data  = 8'h5A;
    bus.in_ready = 1'b1;
    cycles(2);
    bus.clr = 1'b1;
    cycles(1);
    bus.clr = 1'b0;
    cycles(2);
    bus.in_ready = 1'b0;
    cycles(4);
    check_status("clr_wr", 0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    check_pages("clr_wr");

    // reset mid-capture
    pulse(8'h34);
    bus.page = 1'b0;
    cycles(1);
    check("pre_rst_hex", bus.hex_word, 32'h34000000);
    bus.in_data  = 8'h56;
    bus.in_ready = 1'b1;
    cycles(2);
    rstn = 1'b0;
    cycles(1);
    check_status("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_hex", bus.hex_word, 32'h0);
    bus.in_ready = 1'b0;
    cycles(2);
    rstn = 1'b1;
    cycles(2);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
